// File: rtl/noc_link_pipe.sv
// noc_link_pipe: retiming pipeline for one directed mesh link.
// STAGES cascaded 2-entry skid buffers forward, STAGES flops on the vc_ready return path.
module noc_link_pipe #(
  parameter int FLIT_WIDTH = 64,
  parameter int VC_NUM     = 2,
  parameter int STAGES     = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic [FLIT_WIDTH-1:0] up_flit,
  output logic [VC_NUM-1:0]     up_vc_ready,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic [FLIT_WIDTH-1:0] dn_flit,
  input  logic [VC_NUM-1:0]     dn_vc_ready,
  input  logic                  link_enable,
  input  logic                  stat_clear,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  flit_count,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Element k is the interface feeding stage k; element STAGES is the downstream port.
  logic                  stg_valid [STAGES+1];
  logic                  stg_ready [STAGES+1];
  logic [FLIT_WIDTH-1:0] stg_flit  [STAGES+1];

  logic                  accept_en;
  logic                  busy_any;
  logic [VC_NUM-1:0]     vc_dly;
  logic [CNT_WIDTH-1:0]  flit_cnt_q, flit_cnt_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

  // Gating the valid as well keeps the STAGES=0 feed-through consistent with up_ready.
  assign accept_en         = link_enable & ~noc_rst;
  assign stg_valid[0]      = up_valid & accept_en;
  assign stg_flit[0]       = up_flit;
  assign up_ready          = stg_ready[0] & accept_en;
  assign stg_ready[STAGES] = dn_ready;
  assign dn_valid          = stg_valid[STAGES];
  assign dn_flit           = stg_flit[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [1:0]            cnt_q, cnt_d;
    logic [FLIT_WIDTH-1:0] head_q, head_d;
    logic [FLIT_WIDTH-1:0] tail_q, tail_d;
    logic                  push, pop;

    assign push             = stg_valid[k] & stg_ready[k];
    assign pop              = stg_valid[k+1] & stg_ready[k+1];
    assign stg_ready[k]     = (cnt_q != 2'd2);
    assign stg_valid[k+1]   = (cnt_q != 2'd0);
    assign stg_flit[k+1]    = head_q;

    // Two-entry FIFO next state: head is always the oldest entry.
    always_comb begin
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      case ({push, pop})
        2'b10: begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd0) begin
            head_d = stg_flit[k];
          end else begin
            tail_d = stg_flit[k];
          end
        end
        2'b01: begin
          cnt_d  = cnt_q - 2'd1;
          head_d = tail_q;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_d = stg_flit[k];
          end else begin
            head_d = tail_q;
            tail_d = stg_flit[k];
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end

    // Occupancy register.
    always_ff @(posedge noc_clk) begin
      if (noc_rst) begin
        cnt_q <= 2'd0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Payload registers carry no reset; they are only observed while occupied.
    always_ff @(posedge noc_clk) begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Any occupied stage makes the link busy.
  always_comb begin
    busy_any = 1'b0;
    for (int i = 1; i <= STAGES; i++) begin
      busy_any = busy_any | stg_valid[i];
    end
  end
  assign busy = busy_any;

  if (STAGES == 0) begin : g_vc_wire
    assign vc_dly = dn_vc_ready;
  end else begin : g_vc_pipe
    logic [VC_NUM-1:0] vc_q [STAGES];

    // Delay line matching the forward stage count.
    always_ff @(posedge noc_clk) begin
      if (noc_rst) begin
        for (int i = 0; i < STAGES; i++) begin
          vc_q[i] <= {VC_NUM{1'b0}};
        end
      end else begin
        vc_q[0] <= dn_vc_ready;
        for (int i = 1; i < STAGES; i++) begin
          vc_q[i] <= vc_q[i-1];
        end
      end
    end
    assign vc_dly = vc_q[STAGES-1];
  end
  assign up_vc_ready = vc_dly & {VC_NUM{link_enable}};

  // Saturating statistics; clear takes priority over counting.
  always_comb begin
    flit_cnt_d  = flit_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (stat_clear) begin
      flit_cnt_d  = {CNT_WIDTH{1'b0}};
      stall_cnt_d = {CNT_WIDTH{1'b0}};
    end else begin
      if (dn_valid && dn_ready && (flit_cnt_q != CNT_MAX)) begin
        flit_cnt_d = flit_cnt_q + CNT_ONE;
      end else begin
        flit_cnt_d = flit_cnt_q;
      end
      if (dn_valid && !dn_ready && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      flit_cnt_q  <= {CNT_WIDTH{1'b0}};
      stall_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      flit_cnt_q  <= flit_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flit_count  = flit_cnt_q;
  assign stall_count = stall_cnt_q;

endmodule
